// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard detection and forwarding control for a five-stage in-order pipeline
// (IF, ID, EX, MEM, WB). The block keeps a small shadow of the instruction
// class and destination register held in EX, MEM and WB. From that shadow and
// from the instruction sitting in ID it works out three things:
//   - operand forwarding selects for the ID-stage rs1/rs2 operands,
//   - a one-cycle load-use stall (PC hold, IF/ID hold, ID/EX bubble),
//   - the store-data forward used when a store in MEM needs load data in WB.
// Taken branches resolved in ID flush IF/ID unless a stall is pending, in
// which case the branch simply waits one cycle and re-evaluates.
//
// Ports
//   clk               in   rising-edge clock
//   rst_n             in   asynchronous active-low reset
//   rs1use, rs2use    in   ID instruction reads rs1 / rs2
//   hazard_optype_ID  in   ID class: 0 none, 1 ALU, 2 LOAD, 3 STORE
//   rs1addr_ID        in   ID rs1 address
//   rs2addr_ID        in   ID rs2 address
//   rd_ID             in   ID destination address
//   Branch_ID         in   taken branch / JAL / JALR resolved in ID
//   forward_ctrl_A    out  rs1 select: 0 regfile, 1 EX ALU, 2 MEM ALU, 3 MEM load
//   forward_ctrl_B    out  rs2 select, same encoding as forward_ctrl_A
//   forward_ctrl_ls   out  MEM store data: 1 WB load data, 0 pipelined rs2
//   PC_EN_IF          out  PC update enable
//   reg_FD_EN         out  IF/ID register enable
//   reg_FD_flush      out  IF/ID register flush
//   reg_DE_flush      out  ID/EX register flush (bubble insert)
//
// All outputs are combinational from the current ID inputs and the tracked
// stage entries, so the decision is available in the same cycle.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rs1use,
   input  logic          rs2use,
   input  logic [1:0]    hazard_optype_ID,
   input  logic [AW-1:0] rs1addr_ID,
   input  logic [AW-1:0] rs2addr_ID,
   input  logic [AW-1:0] rd_ID,
   input  logic          Branch_ID,
   output logic [1:0]    forward_ctrl_A,
   output logic [1:0]    forward_ctrl_B,
   output logic          forward_ctrl_ls,
   output logic          PC_EN_IF,
   output logic          reg_FD_EN,
   output logic          reg_FD_flush,
   output logic          reg_DE_flush
);

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_ALU   = 2'd1,
      OP_LOAD  = 2'd2,
      OP_STORE = 2'd3
   } optype_e;

   // Forwarding select encoding shared by both ID operands.
   localparam logic [1:0] FWD_RF      = 2'd0;
   localparam logic [1:0] FWD_EX_ALU  = 2'd1;
   localparam logic [1:0] FWD_MEM_ALU = 2'd2;
   localparam logic [1:0] FWD_MEM_LD  = 2'd3;

   // EX and MEM entries also carry the rs2 of a store so that the store-data
   // forward can be decided once the store reaches MEM. WB only needs the
   // producer information.
   typedef struct packed {
      optype_e       op;
      logic [AW-1:0] rd;
      logic [AW-1:0] rs2;
   } stage_t;

   localparam stage_t STAGE_EMPTY = '{op: OP_NONE, rd: '0, rs2: '0};

   stage_t        ex_q,  ex_d;
   stage_t        mem_q, mem_d;
   optype_e       wb_op_q, wb_op_d;
   logic [AW-1:0] wb_rd_q, wb_rd_d;

   optype_e id_op;
   logic    stall;
   logic    ex_load_rs1, ex_load_rs2;

   assign id_op = optype_e'(hazard_optype_ID);

   // A stage can supply a value only if it writes a register, and x0 never
   // counts as a destination.
   function automatic logic is_producer(input optype_e op, input logic [AW-1:0] rd);
      return ((op == OP_ALU) || (op == OP_LOAD)) && (rd != '0);
   endfunction

   function automatic logic src_match(input logic          use_src,
                                      input logic [AW-1:0] addr,
                                      input optype_e       op,
                                      input logic [AW-1:0] rd);
      return use_src && is_producer(op, rd) && (addr == rd);
   endfunction

   // Youngest producer wins. A LOAD in EX is not a forwarding source: that
   // case is handled by the stall, after which the load sits in MEM.
   function automatic logic [1:0] fwd_sel(input logic          use_src,
                                          input logic [AW-1:0] addr,
                                          input stage_t        ex,
                                          input stage_t        mem);
      logic [1:0] sel;
      sel = FWD_RF;
      if (src_match(use_src, addr, ex.op, ex.rd) && (ex.op == OP_ALU)) begin
         sel = FWD_EX_ALU;
      end else if (src_match(use_src, addr, mem.op, mem.rd) && (mem.op == OP_ALU)) begin
         sel = FWD_MEM_ALU;
      end else if (src_match(use_src, addr, mem.op, mem.rd) && (mem.op == OP_LOAD)) begin
         sel = FWD_MEM_LD;
      end
      return sel;
   endfunction

   // ---------------------------------------------------------------------------
   // Load-use detection. A store whose data operand (rs2) comes from the load
   // in EX does not stall: the data is only needed in MEM, by which time the
   // load has reached WB and forward_ctrl_ls routes it across.
   // ---------------------------------------------------------------------------
   always_comb begin
      ex_load_rs1 = 1'b0;
      ex_load_rs2 = 1'b0;
      if (ex_q.op == OP_LOAD) begin
         ex_load_rs1 = src_match(rs1use, rs1addr_ID, ex_q.op, ex_q.rd);
         ex_load_rs2 = src_match(rs2use, rs2addr_ID, ex_q.op, ex_q.rd);
      end
      stall = ex_load_rs1 || (ex_load_rs2 && (id_op != OP_STORE));
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      forward_ctrl_A  = fwd_sel(rs1use, rs1addr_ID, ex_q, mem_q);
      forward_ctrl_B  = fwd_sel(rs2use, rs2addr_ID, ex_q, mem_q);
      forward_ctrl_ls = (mem_q.op == OP_STORE) && (wb_op_q == OP_LOAD) &&
                        (wb_rd_q != '0) && (wb_rd_q == mem_q.rs2);

      PC_EN_IF     = 1'b1;
      reg_FD_EN    = 1'b1;
      reg_FD_flush = 1'b0;
      reg_DE_flush = 1'b0;
      if (stall) begin
         // Stall takes priority over a branch; the branch stays in ID and is
         // resolved again next cycle with the load value forwarded from MEM.
         PC_EN_IF     = 1'b0;
         reg_FD_EN    = 1'b0;
         reg_DE_flush = 1'b1;
      end else if (Branch_ID) begin
         reg_FD_flush = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Stage tracker next state
   // ---------------------------------------------------------------------------
   always_comb begin
      ex_d = STAGE_EMPTY;
      if (!stall) begin
         ex_d.op  = id_op;
         ex_d.rd  = rd_ID;
         ex_d.rs2 = ((id_op == OP_STORE) && rs2use) ? rs2addr_ID : '0;
      end
      mem_d   = ex_q;
      wb_op_d = mem_q.op;
      wb_rd_d = mem_q.rd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q    <= STAGE_EMPTY;
         mem_q   <= STAGE_EMPTY;
         wb_op_q <= OP_NONE;
         wb_rd_q <= '0;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_op_q <= wb_op_d;
         wb_rd_q <= wb_rd_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. The driver applies one ID-stage vector per
// clock cycle just after the rising edge and pushes the hand-computed output
// word for that cycle into exp_q. The monitor samples the outputs on the
// falling edge and checks them against the head of the queue.
//
// Output word layout: {fwd_A[1:0], fwd_B[1:0], fwd_ls, pc_en, fd_en,
//                      fd_flush, de_flush}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int AW = 5;

   localparam logic [1:0] NONE = 2'd0;
   localparam logic [1:0] ALU  = 2'd1;
   localparam logic [1:0] LOAD = 2'd2;
   localparam logic [1:0] STOR = 2'd3;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          rs1use = 1'b0;
   logic          rs2use = 1'b0;
   logic [1:0]    hazard_optype_ID = 2'd0;
   logic [AW-1:0] rs1addr_ID = '0;
   logic [AW-1:0] rs2addr_ID = '0;
   logic [AW-1:0] rd_ID = '0;
   logic          Branch_ID = 1'b0;
   logic [1:0]    forward_ctrl_A, forward_ctrl_B;
   logic          forward_ctrl_ls, PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;

   hazard_ctrl #(.AW(AW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .rs1use           (rs1use),
      .rs2use           (rs2use),
      .hazard_optype_ID (hazard_optype_ID),
      .rs1addr_ID       (rs1addr_ID),
      .rs2addr_ID       (rs2addr_ID),
      .rd_ID            (rd_ID),
      .Branch_ID        (Branch_ID),
      .forward_ctrl_A   (forward_ctrl_A),
      .forward_ctrl_B   (forward_ctrl_B),
      .forward_ctrl_ls  (forward_ctrl_ls),
      .PC_EN_IF         (PC_EN_IF),
      .reg_FD_EN        (reg_FD_EN),
      .reg_FD_flush     (reg_FD_flush),
      .reg_DE_flush     (reg_DE_flush)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [8:0] exp_q[$];
   string      name_q[$];
   int         n_checks = 0;
   int         n_fail   = 0;

   function automatic logic [8:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic ls, input logic pc, input logic fden,
                                     input logic fdfl, input logic de);
      return {fa, fb, ls, pc, fden, fdfl, de};
   endfunction

   logic [8:0] idle_v;
   logic [8:0] stall_v;
   initial begin
      idle_v  = ev(2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      stall_v = ev(2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   end

   // Monitor: combinational outputs are presented every cycle once a vector
   // has been applied.
   always @(negedge clk) begin
      logic [8:0] act;
      logic [8:0] expv;
      string      nm;
      if (exp_q.size() > 0) begin
         expv = exp_q.pop_front();
         nm   = name_q.pop_front();
         act  = {forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls, PC_EN_IF,
                 reg_FD_EN, reg_FD_flush, reg_DE_flush};
         n_checks++;
         if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got fa=%0d fb=%0d ls=%0b pc=%0b fden=%0b fdfl=%0b de=%0b, expected fa=%0d fb=%0d ls=%0b pc=%0b fden=%0b fdfl=%0b de=%0b",
                     nm, act[8:7], act[6:5], act[4], act[3], act[2], act[1], act[0],
                     expv[8:7], expv[6:5], expv[4], expv[3], expv[2], expv[1], expv[0]);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver
   // ---------------------------------------------------------------------------
   task automatic drv(input string nm, input logic rst, input logic u1, input logic u2,
                      input logic [1:0] op, input int r1, input int r2, input int rd,
                      input logic br, input logic [8:0] expv);
      @(posedge clk);
      #1;
      rst_n            = rst;
      rs1use           = u1;
      rs2use           = u2;
      hazard_optype_ID = op;
      rs1addr_ID       = AW'(r1);
      rs2addr_ID       = AW'(r2);
      rd_ID            = AW'(rd);
      Branch_ID        = br;
      exp_q.push_back(expv);
      name_q.push_back(nm);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      #1;
      // Reset with an ALU x5 presented in ID: nothing is tracked yet.
      drv("reset",         0, 0, 0, ALU,  0, 0, 5, 0, idle_v);
      drv("first_alu",     1, 0, 0, ALU,  0, 0, 5, 0, idle_v);
      // add x6,x5,x7 with ALU x5 in EX
      drv("ex_alu_fwd",    1, 1, 1, ALU,  5, 7, 6, 0, ev(2'd1, 2'd0, 0, 1, 1, 0, 0));
      drv("alu_x5_a",      1, 0, 0, ALU,  0, 0, 5, 0, idle_v);
      drv("alu_x5_b",      1, 0, 0, ALU,  0, 0, 5, 0, idle_v);
      // x5 in EX and MEM: youngest (EX) wins
      drv("youngest_wins", 1, 1, 1, ALU,  5, 6, 8, 0, ev(2'd1, 2'd0, 0, 1, 1, 0, 0));
      // EX=ALU x8, MEM=ALU x5
      drv("mem_alu_fwd",   1, 1, 1, ALU,  5, 8, 9, 0, ev(2'd2, 2'd1, 0, 1, 1, 0, 0));
      drv("alu_x0",        1, 0, 0, ALU,  0, 0, 0, 0, idle_v);
      drv("x0_no_fwd",     1, 1, 1, ALU,  0, 0, 10, 0, idle_v);
      // lw x5,0(x1) then add x6,x5,x0
      drv("lw_x5",         1, 1, 0, LOAD, 1, 0, 5, 0, idle_v);
      drv("load_use_stl",  1, 1, 1, ALU,  5, 0, 6, 0, stall_v);
      drv("load_use_fwd",  1, 1, 1, ALU,  5, 0, 6, 0, ev(2'd3, 2'd0, 0, 1, 1, 0, 0));
      // lw x5,0(x1) then sw x5,0(x1)
      drv("lw_x5_st",      1, 1, 0, LOAD, 1, 0, 5, 0, idle_v);
      drv("store_no_stl",  1, 1, 1, STOR, 1, 5, 0, 0, idle_v);
      drv("ls_not_yet",    1, 0, 0, NONE, 0, 0, 0, 0, idle_v);
      drv("ls_fwd",        1, 0, 0, NONE, 0, 0, 0, 0, ev(2'd0, 2'd0, 1, 1, 1, 0, 0));
      drv("ls_one_cycle",  1, 0, 0, NONE, 0, 0, 0, 0, idle_v);
      // Branch with no hazard
      drv("branch_flush",  1, 0, 0, ALU,  0, 0, 7, 1, ev(2'd0, 2'd0, 0, 1, 1, 1, 0));
      drv("lw_x5_br",      1, 1, 0, LOAD, 2, 0, 5, 0, idle_v);
      // beq x5,x0 behind the load: stall wins, then flush with MEM load fwd
      drv("branch_stall",  1, 1, 1, NONE, 5, 0, 0, 1, stall_v);
      drv("branch_after",  1, 1, 1, NONE, 5, 0, 0, 1, ev(2'd3, 2'd0, 0, 1, 1, 1, 0));
      // Reset while a load-use pair is present
      drv("lw_x9",         1, 0, 0, LOAD, 0, 0, 9, 0, idle_v);
      drv("reset_mid_stl", 0, 1, 0, ALU,  9, 0, 10, 0, idle_v);
      drv("post_reset",    1, 1, 0, ALU,  9, 0, 10, 0, idle_v);
      drv("post_rst_fwd",  1, 1, 1, ALU, 10, 9, 11, 0, ev(2'd1, 2'd0, 0, 1, 1, 0, 0));
      // rs2 load-use on a non-store, with rs1 forwarded from MEM ALU
      drv("lw_x12",        1, 0, 0, LOAD, 0, 0, 12, 0, idle_v);
      drv("rs2_load_stl",  1, 1, 1, ALU, 11, 12, 13, 0, ev(2'd2, 2'd0, 0, 0, 0, 0, 1));
      drv("rs2_load_fwd",  1, 1, 1, ALU, 11, 12, 13, 0, ev(2'd0, 2'd3, 0, 1, 1, 0, 0));
      drv("tail_idle",     1, 0, 0, NONE, 0, 0, 0, 0, idle_v);

      // Let the monitor drain the last vector.
      @(posedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
